// File: rtl/cluster_event_buffer.sv
// cluster_event_buffer
//   Per-core sticky event buffer with event/IRQ masking, a small config
//   register file and the wait-for-event handshake that gates the core clock.
//   Optional build macro: EVT_EDGE_DETECT_EN
//     defined   -> only rising edges of events_i set buffer bits
//     undefined -> events_i is level-sensitive (re-sets every cycle it is high)
module cluster_event_buffer #(
  parameter int NB_EVT   = 32,
  parameter int EVT_ID_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_EVT-1:0]   events_i,
  input  logic                reg_req_i,
  input  logic                reg_we_i,
  input  logic [2:0]          reg_addr_i,
  input  logic [31:0]         reg_wdata_i,
  output logic                reg_ack_o,
  output logic [31:0]         reg_rdata_o,
  input  logic                wait_req_i,
  output logic                wait_ack_o,
  input  logic                core_busy_i,
  output logic                core_clk_en_o,
  output logic                irq_req_o,
  output logic [EVT_ID_W-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic [EVT_ID_W-1:0] irq_ack_id_i
);

  localparam logic [2:0] ADDR_EVT_MASK     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd1;
  localparam logic [2:0] ADDR_BUFFER       = 3'd2;
  localparam logic [2:0] ADDR_BUF_MASKED   = 3'd3;
  localparam logic [2:0] ADDR_BUF_CLR      = 3'd4;
  localparam logic [2:0] ADDR_EVT_MASK_SET = 3'd5;
  localparam logic [2:0] ADDR_EVT_MASK_CLR = 3'd6;

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE,
    ST_IRQWAKE
  } state_t;

  state_t                state_reg, state_next;
  logic [NB_EVT-1:0]     buffer_reg, buffer_next;
  logic [NB_EVT-1:0]     evt_mask_reg, evt_mask_next;
  logic [NB_EVT-1:0]     irq_mask_reg, irq_mask_next;
  logic [NB_EVT-1:0]     evt_set, evt_clr, masked, irq_pend;
  logic [NB_EVT-1:0]     wdata_evt;
  logic [(1<<EVT_ID_W)-1:0] ack_dec;
  logic                  ack_reg, ack_next;
  logic                  wake_ack;
  logic                  clk_en;
  logic                  irq_req_reg;
  logic [EVT_ID_W-1:0]   irq_id_reg, irq_id_next;
  logic                  reg_ack_reg;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  reg_wr, reg_rd;

  assign reg_wr    = reg_req_i & reg_we_i;
  assign reg_rd    = reg_req_i & ~reg_we_i;
  assign wdata_evt = reg_wdata_i[NB_EVT-1:0];
  assign masked    = buffer_reg & evt_mask_reg;
  assign irq_pend  = buffer_reg & irq_mask_reg;

`ifdef EVT_EDGE_DETECT_EN
  logic [NB_EVT-1:0] events_q;

  // Previous sample of the event lines for rising-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) events_q <= '0;
    else         events_q <= events_i;
  end

  assign evt_set = events_i & ~events_q;
`else
  assign evt_set = events_i;
`endif

  // Collect all clear sources: BUF_CLR write, wait-ack auto-clear, IRQ ack
  always_comb begin
    ack_dec               = '0;
    ack_dec[irq_ack_id_i] = irq_ack_i;
    evt_clr               = ack_dec[NB_EVT-1:0];
    if (reg_wr && reg_addr_i == ADDR_BUF_CLR) evt_clr = evt_clr | wdata_evt;
    if (wait_ack_o)                           evt_clr = evt_clr | masked;
  end

  // Per-bit sticky update; a set in the same cycle always beats a clear
  generate
    for (genvar gi = 0; gi < NB_EVT; gi++) begin : g_buf_bit
      assign buffer_next[gi] = evt_set[gi] | (buffer_reg[gi] & ~evt_clr[gi]);
    end
  endgenerate

  // Mask register writes (direct, set-bits and clear-bits forms)
  always_comb begin
    evt_mask_next = evt_mask_reg;
    irq_mask_next = irq_mask_reg;
    if (reg_wr) begin
      case (reg_addr_i)
        ADDR_EVT_MASK:     evt_mask_next = wdata_evt;
        ADDR_IRQ_MASK:     irq_mask_next = wdata_evt;
        ADDR_EVT_MASK_SET: evt_mask_next = evt_mask_reg | wdata_evt;
        ADDR_EVT_MASK_CLR: evt_mask_next = evt_mask_reg & ~wdata_evt;
        default:           ;
      endcase
    end
  end

  // Read mux, sampled on the request cycle; write-only and unused offsets read 0
  always_comb begin
    rdata_next = '0;
    if (reg_rd) begin
      case (reg_addr_i)
        ADDR_EVT_MASK:   rdata_next[NB_EVT-1:0] = evt_mask_reg;
        ADDR_IRQ_MASK:   rdata_next[NB_EVT-1:0] = irq_mask_reg;
        ADDR_BUFFER:     rdata_next[NB_EVT-1:0] = buffer_reg;
        ADDR_BUF_MASKED: rdata_next[NB_EVT-1:0] = masked;
        default:         ;
      endcase
    end
  end

  // Lowest pending IRQ index (scan downward so the lowest index wins)
  always_comb begin
    irq_id_next = '0;
    for (int i = NB_EVT - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_id_next = EVT_ID_W'(i);
    end
  end

  // Wait-for-event FSM: next state, clock enable and ack generation
  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    wake_ack   = 1'b0;
    clk_en     = 1'b1;
    case (state_reg)
      ST_ACTIVE: begin
        // ack_reg blocks a second trigger while the core still holds the request
        if (wait_req_i && !ack_reg) begin
          if (|masked) ack_next   = 1'b1;
          else         state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!wait_req_i)       state_next = ST_ACTIVE;
        else if (|masked)      state_next = ST_WAKE;
        else if (!core_busy_i) state_next = ST_SLEEP;
      end
      ST_SLEEP: begin
        clk_en = 1'b0;
        if (|masked)          state_next = ST_WAKE;
        else if (irq_req_reg) state_next = ST_IRQWAKE;
      end
      ST_WAKE: begin
        wake_ack   = 1'b1;
        state_next = ST_ACTIVE;
      end
      ST_IRQWAKE: begin
        if (irq_ack_i) state_next = ST_DRAIN;
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  // All state; async reset returns to ACTIVE so the core clock restarts at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_ACTIVE;
      buffer_reg   <= '0;
      evt_mask_reg <= '0;
      irq_mask_reg <= '0;
      ack_reg      <= 1'b0;
      irq_req_reg  <= 1'b0;
      irq_id_reg   <= '0;
      reg_ack_reg  <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      buffer_reg   <= buffer_next;
      evt_mask_reg <= evt_mask_next;
      irq_mask_reg <= irq_mask_next;
      ack_reg      <= ack_next;
      irq_req_reg  <= |irq_pend;
      irq_id_reg   <= irq_id_next;
      reg_ack_reg  <= reg_req_i;
      rdata_reg    <= rdata_next;
    end
  end

  assign wait_ack_o    = ack_reg | wake_ack;
  assign core_clk_en_o = clk_en;
  assign irq_req_o     = irq_req_reg;
  assign irq_id_o      = irq_id_reg;
  assign reg_ack_o     = reg_ack_reg;
  assign reg_rdata_o   = rdata_reg;

endmodule
